// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into single, double and long events,
// with auto-repeat while a long press is held. Emits one-cycle pulses and an event count.
module key_event_classifier #(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_MS   = 1000,
    parameter int DCLK_MS   = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic       single_p,
    output logic       double_p,
    output logic       long_p,
    output logic       repeat_p,
    output logic       busy,
    output logic [9:0] evt_cnt
);

    localparam int              DIV_W       = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [11:0]     LONG_LAST   = 12'(LONG_MS - 1);
    localparam logic [11:0]     DCLK_LAST   = 12'(DCLK_MS - 1);
    localparam logic [11:0]     REPEAT_LAST = 12'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        WAIT2    = 3'd2,
        LONG     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             k_d;
    logic [DIV_W-1:0] div_cnt;
    logic [11:0]      ms_cnt;
    logic             press, tick, restart, clr;
    logic             sgl_c, dbl_c, long_c, rep_c;

    assign press = k_d & ~key_n;
    assign tick  = (div_cnt == DIV_LAST);
    assign clr   = (state_nxt != state) | restart;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Release beats threshold in PRESS1/LONG; a new press beats the gap timeout in WAIT2.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        sgl_c     = 1'b0;
        dbl_c     = 1'b0;
        long_c    = 1'b0;
        rep_c     = 1'b0;
        case (state)
            IDLE: begin
                if (press) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (key_n) begin
                    state_nxt = WAIT2;
                end else if (tick && ms_cnt == LONG_LAST) begin
                    long_c    = 1'b1;
                    state_nxt = LONG;
                end
            end
            LONG: begin
                if (key_n) begin
                    state_nxt = IDLE;
                end else if (tick && ms_cnt == REPEAT_LAST) begin
                    rep_c   = 1'b1;
                    restart = 1'b1;
                end
            end
            WAIT2: begin
                if (press) begin
                    dbl_c     = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (tick && ms_cnt == DCLK_LAST) begin
                    sgl_c     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (key_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // k_d resets low so a key held through reset is not seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_d      <= 1'b0;
            div_cnt  <= '0;
            ms_cnt   <= '0;
            single_p <= 1'b0;
            double_p <= 1'b0;
            long_p   <= 1'b0;
            repeat_p <= 1'b0;
            evt_cnt  <= '0;
        end else begin
            k_d      <= key_n;
            single_p <= sgl_c;
            double_p <= dbl_c;
            long_p   <= long_c;
            repeat_p <= rep_c;
            if (sgl_c || dbl_c || long_c) evt_cnt <= evt_cnt + 10'd1;
            if (clr) begin
                div_cnt <= '0;
                ms_cnt  <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                if (ms_cnt != 12'hFFF) ms_cnt <= ms_cnt + 12'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Bench for key_event_classifier: table-driven press patterns, hand sequences for
// reset and counter wrap, then random key activity against an elapsed-time model.
module tb_key_event_classifier;

    localparam int TICK_DIV  = 4;
    localparam int LONG_MS   = 10;
    localparam int DCLK_MS   = 5;
    localparam int REPEAT_MS = 3;

    logic       clk, rst, key_n;
    logic       single_p, double_p, long_p, repeat_p, busy;
    logic [9:0] evt_cnt;

    key_event_classifier #(
        .TICK_DIV(TICK_DIV), .LONG_MS(LONG_MS), .DCLK_MS(DCLK_MS), .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .single_p(single_p), .double_p(double_p), .long_p(long_p), .repeat_p(repeat_p),
        .busy(busy), .evt_cnt(evt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: phase plus elapsed clock edges since the phase was entered.
    localparam int P_IDLE = 0, P_PRESS = 1, P_LONG = 2, P_GAP = 3, P_HELD = 4;
    int m_ph, m_el, m_nx, m_cnt;
    bit m_prev, m_pr, m_rs, m_sgl, m_dbl, m_lng, m_rep;

    always @(posedge clk) begin
        if (!rst) begin
            m_ph = P_IDLE; m_el = 0; m_prev = 1'b0; m_cnt = 0;
            m_sgl = 0; m_dbl = 0; m_lng = 0; m_rep = 0;
        end else begin
            m_pr = m_prev && !key_n;
            m_sgl = 0; m_dbl = 0; m_lng = 0; m_rep = 0; m_rs = 0;
            m_nx = m_ph;
            case (m_ph)
                P_IDLE:  if (m_pr) m_nx = P_PRESS;
                P_PRESS: if (key_n) m_nx = P_GAP;
                         else if (m_el + 1 == LONG_MS * TICK_DIV) begin m_lng = 1; m_nx = P_LONG; end
                P_LONG:  if (key_n) m_nx = P_IDLE;
                         else if (m_el + 1 == REPEAT_MS * TICK_DIV) begin m_rep = 1; m_rs = 1; end
                P_GAP:   if (m_pr) begin m_dbl = 1; m_nx = P_HELD; end
                         else if (m_el + 1 == DCLK_MS * TICK_DIV) begin m_sgl = 1; m_nx = P_IDLE; end
                default: if (key_n) m_nx = P_IDLE;
            endcase
            if (m_nx != m_ph || m_rs) m_el = 0; else m_el++;
            m_ph   = m_nx;
            m_prev = key_n;
            m_cnt  = (m_cnt + int'(m_sgl) + int'(m_dbl) + int'(m_lng)) % 1024;
        end
    end

    task automatic do_edge(input logic k);
        key_n = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        do_edge(1'b1);
        do_edge(1'b1);
        rst = 1'b1;
        repeat (3) do_edge(1'b1);
    endtask

    typedef struct {
        int low1, gap, low2, len;
        int s_at, d_at, l_at;
        int ns, nd, nl, nr, evt;
    } row_t;

    int   s_at, d_at, l_at, ns, nd, nl, nr;
    logic busy_h [0:199];

    task automatic seq_run(input int low1, input int gap, input int low2, input int len);
        logic k;
        s_at = -1; d_at = -1; l_at = -1; ns = 0; nd = 0; nl = 0; nr = 0;
        for (int i = 0; i < len; i++) begin
            k = !(i < low1 || (i >= low1 + gap && i < low1 + gap + low2));
            do_edge(k);
            if (single_p) begin ns++; if (s_at < 0) s_at = i; end
            if (double_p) begin nd++; if (d_at < 0) d_at = i; end
            if (long_p)   begin nl++; if (l_at < 0) l_at = i; end
            if (repeat_p) nr++;
            busy_h[i] = busy;
        end
    endtask

    row_t rows [8];
    int   cnt_pulse, lvl, seg;

    initial begin
        rst = 1'b0;
        key_n = 1'b1;
        rows[0] = '{8,  0,  0,   60,  28, -1, -1, 1, 0, 0, 0, 1};
        rows[1] = '{8,  8,  100, 140, -1, 16, -1, 0, 1, 0, 0, 1};
        rows[2] = '{80, 0,  0,   100, -1, -1, 40, 0, 0, 1, 3, 1};
        rows[3] = '{40, 0,  0,   80,  60, -1, -1, 1, 0, 0, 0, 1};
        rows[4] = '{8,  20, 10,  60,  -1, 28, -1, 0, 1, 0, 0, 1};
        rows[5] = '{8,  21, 5,   80,  28, -1, -1, 2, 0, 0, 0, 2};
        rows[6] = '{52, 0,  0,   80,  -1, -1, 40, 0, 0, 1, 0, 1};
        rows[7] = '{1,  0,  0,   40,  21, -1, -1, 1, 0, 0, 0, 1};

        @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset evt_cnt", int'(evt_cnt), 0);
        chk("reset pulses", int'({single_p, double_p, long_p, repeat_p}), 0);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            seq_run(rows[r].low1, rows[r].gap, rows[r].low2, rows[r].len);
            chk($sformatf("row%0d single_at", r), s_at, rows[r].s_at);
            chk($sformatf("row%0d double_at", r), d_at, rows[r].d_at);
            chk($sformatf("row%0d long_at", r), l_at, rows[r].l_at);
            chk($sformatf("row%0d n_single", r), ns, rows[r].ns);
            chk($sformatf("row%0d n_double", r), nd, rows[r].nd);
            chk($sformatf("row%0d n_long", r), nl, rows[r].nl);
            chk($sformatf("row%0d n_repeat", r), nr, rows[r].nr);
            chk($sformatf("row%0d evt_cnt", r), int'(evt_cnt), rows[r].evt);
            chk($sformatf("row%0d busy_end", r), int'(busy), 0);
            if (rows[r].s_at > 0) begin
                chk($sformatf("row%0d busy_before_single", r), int'(busy_h[rows[r].s_at - 1]), 1);
                chk($sformatf("row%0d busy_at_single", r), int'(busy_h[rows[r].s_at]), 0);
            end
        end

        // Reset in the middle of a long press while the key stays down.
        do_reset();
        seq_run(50, 0, 50, 50);
        chk("hold long_seen", nl, 1);
        chk("hold busy", int'(busy), 1);
        rst = 1'b0;
        do_edge(1'b0);
        do_edge(1'b0);
        chk("midreset pulses", int'({single_p, double_p, long_p, repeat_p}), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset evt_cnt", int'(evt_cnt), 0);
        rst = 1'b1;
        cnt_pulse = 0;
        for (int i = 0; i < 60; i++) begin
            do_edge(1'b0);
            cnt_pulse += int'(single_p) + int'(double_p) + int'(long_p) + int'(repeat_p) + int'(busy);
        end
        chk("held_after_reset activity", cnt_pulse, 0);
        repeat (5) do_edge(1'b1);
        chk("released busy", int'(busy), 0);
        seq_run(8, 0, 0, 40);
        chk("post_reset single_at", s_at, 28);
        chk("post_reset evt_cnt", int'(evt_cnt), 1);

        // Counter wrap over 1025 single clicks.
        do_reset();
        ns = 0;
        for (int c = 0; c < 1025; c++) begin
            do_edge(1'b0);
            for (int i = 0; i < 21; i++) begin
                do_edge(1'b1);
                if (single_p) ns++;
            end
            if (c == 1022) chk("wrap evt_1023", int'(evt_cnt), 1023);
            if (c == 1023) begin
                chk("wrap evt_1024", int'(evt_cnt), 0);
                chk("wrap n_single", ns, 1024);
            end
            if (c == 1024) chk("wrap evt_1025", int'(evt_cnt), 1);
        end

        // Random key activity against the model.
        do_reset();
        lvl = 1;
        for (int s = 0; s < 120; s++) begin
            lvl = 1 - lvl;
            seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 70);
            for (int i = 0; i < seg; i++) begin
                rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
                do_edge(lvl[0]);
                chk("rnd single_p", int'(single_p), int'(m_sgl));
                chk("rnd double_p", int'(double_p), int'(m_dbl));
                chk("rnd long_p", int'(long_p), int'(m_lng));
                chk("rnd repeat_p", int'(repeat_p), int'(m_rep));
                chk("rnd busy", int'(busy), int'(m_ph != P_IDLE));
                chk("rnd evt_cnt", int'(evt_cnt), m_cnt);
                chk("rnd onehot", int'(single_p) + int'(double_p) + int'(long_p) + int'(repeat_p) <= 1, 1);
            end
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
